div_controller: RTL and testbench

- Sequencing FSM for the restoring-division datapath. The datapath holds A (remainder), Q (dividend, then quotient) and M (divisor), plus a shared add/sub ALU.
- Issues clear, load, shift, ALU-select, restore and quotient-bit strobes.
- Owns the iteration counter and exposes a start/busy/done handshake to the issuing unit.

---
 rtl/div_controller_if.sv | 33 +++
 rtl/div_controller.sv | 126 ++++++++++++
 tb/tb_div_controller.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/div_controller_if.sv
// Handshake and strobe bundle between the issuing unit / datapath (master) and the
// restoring-division sequencer (slave).
interface div_controller_if #(
  parameter int unsigned CW = 4
);
  logic          c_start;
  logic          c_abort;
  logic          c_a_msb;
  logic          c_m_zero;
  logic          c_clr_A;
  logic          c_load_M;
  logic          c_load_Q;
  logic          c_shift_AQ;
  logic          c_sel_alu;
  logic          c_load_A;
  logic          c_set_q0;
  logic          c_busy;
  logic          c_done;
  logic          c_div_err;
  logic [CW-1:0] c_count;

  modport master (
    output c_start, c_abort, c_a_msb, c_m_zero,
    input  c_clr_A, c_load_M, c_load_Q, c_shift_AQ, c_sel_alu, c_load_A, c_set_q0,
    input  c_busy, c_done, c_div_err, c_count
  );

  modport slave (
    input  c_start, c_abort, c_a_msb, c_m_zero,
    output c_clr_A, c_load_M, c_load_Q, c_shift_AQ, c_sel_alu, c_load_A, c_set_q0,
    output c_busy, c_done, c_div_err, c_count
  );
endinterface

// File: rtl/div_controller.sv
// Sequencing FSM for a restoring divider: CLEAR, LOAD, then WIDTH x (SHIFT, SUB, TEST), DONE.
// Optional divide-by-zero check state enabled by defining DIV_CTRL_ZERO_CHECK_EN.
module div_controller #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input logic            c_clk,
  input logic            c_reset,
  div_controller_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle, StClear, StLoad, StZchk, StShift, StSub, StTest, StDone
  } state_e;

  state_e        state_q;
  logic [CW-1:0] count_q;

`ifdef DIV_CTRL_ZERO_CHECK_EN
  logic err_q;
`else
  logic unused_m_zero;
  assign unused_m_zero = bus.c_m_zero;
`endif

  always_ff @(posedge c_clk or posedge c_reset) begin
    if (c_reset) begin
      state_q <= StIdle;
      count_q <= '0;
`ifdef DIV_CTRL_ZERO_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else if (bus.c_abort) begin
      state_q <= StIdle;
      count_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.c_start) begin
            state_q <= StClear;
`ifdef DIV_CTRL_ZERO_CHECK_EN
            err_q   <= 1'b0;
`endif
          end
        end
        StClear: begin
          count_q <= CW'(WIDTH);
          state_q <= StLoad;
        end
`ifdef DIV_CTRL_ZERO_CHECK_EN
        StLoad: state_q <= StZchk;
        StZchk: begin
          if (bus.c_m_zero) begin
            err_q   <= 1'b1;
            state_q <= StDone;
          end else begin
            state_q <= StShift;
          end
        end
`else
        StLoad: state_q <= StShift;
`endif
        StShift: state_q <= StSub;
        StSub:   state_q <= StTest;
        StTest: begin
          // Guard keeps the counter from wrapping even if TEST were reached at zero.
          if (count_q != '0) count_q <= count_q - 1'b1;
          state_q <= (count_q <= CW'(1)) ? StDone : StShift;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  logic clr_a, load_m, load_q, shift_aq, sel_alu, load_a, set_q0, done, div_err;

  always_comb begin
    clr_a    = 1'b0;
    load_m   = 1'b0;
    load_q   = 1'b0;
    shift_aq = 1'b0;
    sel_alu  = 1'b0;
    load_a   = 1'b0;
    set_q0   = 1'b0;
    done     = 1'b0;
    div_err  = 1'b0;
    unique case (state_q)
      StClear: clr_a = 1'b1;
      StLoad: begin
        load_m = 1'b1;
        load_q = 1'b1;
      end
      StShift: shift_aq = 1'b1;
      StSub: begin
        sel_alu = 1'b1;
        load_a  = 1'b1;
      end
      // Negative trial result: restore with A+M; otherwise record a quotient one.
      StTest: begin
        if (bus.c_a_msb) load_a = 1'b1;
        else             set_q0 = 1'b1;
      end
      StDone: begin
        done = 1'b1;
`ifdef DIV_CTRL_ZERO_CHECK_EN
        div_err = err_q;
`endif
      end
      default: ;
    endcase
  end

  assign bus.c_clr_A    = clr_a;
  assign bus.c_load_M   = load_m;
  assign bus.c_load_Q   = load_q;
  assign bus.c_shift_AQ = shift_aq;
  assign bus.c_sel_alu  = sel_alu;
  assign bus.c_load_A   = load_a;
  assign bus.c_set_q0   = set_q0;
  assign bus.c_busy     = (state_q != StIdle);
  assign bus.c_done     = done;
  assign bus.c_div_err  = div_err;
  assign bus.c_count    = count_q;

endmodule

// File: tb/tb_div_controller.sv
// Randomised self-checking bench for div_controller with a behavioural restoring-divider
// datapath; expected results come from plain integer division.
module tb_div_controller;
  localparam int unsigned W  = 8;
  localparam int unsigned CW = $clog2(W + 1);
`ifdef DIV_CTRL_ZERO_CHECK_EN
  localparam bit ZC = 1'b1;
`else
  localparam bit ZC = 1'b0;
`endif

  logic c_clk = 1'b0;
  logic c_reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  div_controller_if #(.CW(CW)) bus ();

  div_controller #(.WIDTH(W), .CW(CW)) dut (
    .c_clk   (c_clk),
    .c_reset (c_reset),
    .bus     (bus)
  );

  always #5 c_clk = ~c_clk;

  // Datapath model driven by the controller's strobes.
  logic [W:0]   a_r = '0;
  logic [W-1:0] q_r = '0;
  logic [W-1:0] m_r = '0;
  logic [W-1:0] dvd_bus = '0;
  logic [W-1:0] dvs_bus = '0;

  assign bus.c_a_msb  = a_r[W];
  assign bus.c_m_zero = (m_r == '0);

  always @(posedge c_clk) begin
    if (bus.c_clr_A)    a_r <= '0;
    if (bus.c_load_M)   m_r <= dvs_bus;
    if (bus.c_load_Q)   q_r <= dvd_bus;
    if (bus.c_shift_AQ) {a_r, q_r} <= {a_r[W-1:0], q_r, 1'b0};
    if (bus.c_load_A)   a_r <= bus.c_sel_alu ? a_r - {1'b0, m_r} : a_r + {1'b0, m_r};
    if (bus.c_set_q0)   q_r[0] <= 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {17'd0, bus.c_clr_A, bus.c_load_M, bus.c_load_Q, bus.c_shift_AQ, bus.c_sel_alu,
            bus.c_load_A, bus.c_set_q0, bus.c_busy, bus.c_done, bus.c_div_err,
            CW'(bus.c_count)};
  endfunction

  // intr: 0 none, 1 abort at cycle 10, 2 reset at cycle 10. poke: extra starts at 5 and 12.
  task automatic run_op(input logic [W-1:0] dvd, input logic [W-1:0] dvs, input int intr,
                        input bit poke);
    int done_cyc, n_done, shifts, restores, sets, guard, limit, lat, ones;
    logic err_seen;
    logic [W-1:0] exp_q, exp_r;
    guard = 0;
    @(negedge c_clk);
    while (bus.c_busy && guard < 100) begin
      @(negedge c_clk);
      guard++;
    end
    check_eq("idle_before_start", 32'(bus.c_busy), 32'd0);
    dvd_bus = dvd;
    dvs_bus = dvs;
    bus.c_start = 1'b1;
    @(posedge c_clk);
    #1;
    done_cyc = 0; n_done = 0; shifts = 0; restores = 0; sets = 0; err_seen = 1'b0;
    limit = (intr != 0) ? 40 : 3 * W + 12;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      bus.c_start = poke && (cyc == 5 || cyc == 12);
      if (intr == 1 && cyc == 10) bus.c_abort = 1'b1;
      if (intr == 2 && cyc == 10) begin
        c_reset = 1'b1;
        #1;
        check_eq("reset_outs_zero", outs(), 32'd0);
      end
      if (cyc == 11) begin
        bus.c_abort = 1'b0;
        c_reset = 1'b0;
        if (intr != 0) check_eq("intr_idle_c11", outs(), 32'd0);
      end
      if (cyc == 1) check_eq("busy_c1", 32'(bus.c_busy), 32'd1);
      if (cyc == 2 && intr == 0) check_eq("count_after_clear", 32'(bus.c_count), W);
      if (bus.c_done) begin
        n_done++;
        done_cyc = cyc;
        err_seen = bus.c_div_err;
        check_eq("count_in_done", 32'(bus.c_count), 32'd0);
      end
      if (bus.c_shift_AQ) shifts++;
      if (bus.c_load_A && !bus.c_sel_alu) restores++;
      if (bus.c_set_q0) sets++;
      if (n_done != 0 && intr == 0) break;
      @(posedge c_clk);
      #1;
    end
    if (intr != 0) begin
      check_eq("no_done_after_intr", n_done, 0);
    end else if (ZC && dvs == '0) begin
      check_eq("zchk_done_cycle", done_cyc, 4);
      check_eq("zchk_div_err", 32'(err_seen), 32'd1);
      check_eq("zchk_no_shifts", shifts, 0);
    end else begin
      lat   = ZC ? 4 + 3 * W : 3 + 3 * W;
      exp_q = (dvs == '0) ? {W{1'b1}} : dvd / dvs;
      exp_r = (dvs == '0) ? dvd : dvd % dvs;
      ones  = $countones(exp_q);
      check_eq("done_cycle", done_cyc, lat);
      check_eq("done_count", n_done, 1);
      check_eq("quotient", 32'(q_r), 32'(exp_q));
      check_eq("remainder", 32'(a_r[W-1:0]), 32'(exp_r));
      check_eq("shift_pulses", shifts, W);
      check_eq("set_q0_pulses", sets, ones);
      check_eq("restore_cycles", restores, W - ones);
      check_eq("div_err", 32'(err_seen), 32'd0);
    end
  endtask

  initial begin
    bus.c_start = 1'b0;
    bus.c_abort = 1'b0;
    repeat (2) @(negedge c_clk);
    check_eq("outs_in_reset", outs(), 32'd0);
    c_reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge c_clk);
      check_eq("idle_outs", outs(), 32'd0);
    end

    // Abort in IDLE blocks a same-cycle start.
    @(negedge c_clk);
    bus.c_start = 1'b1;
    bus.c_abort = 1'b1;
    @(negedge c_clk);
    check_eq("abort_blocks_start", outs(), 32'd0);
    bus.c_start = 1'b0;
    bus.c_abort = 1'b0;

    run_op(8'd100, 8'd7, 0, 1'b0);
    run_op(8'd100, 8'd0, 0, 1'b0);
    run_op(8'd100, 8'd7, 0, 1'b1);
    run_op(8'd255, 8'd3, 1, 1'b0);
    run_op(8'd255, 8'd3, 2, 1'b0);
    run_op(8'd255, 8'd3, 0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      run_op(W'($urandom), W'($urandom_range(255, 1)), 0, 1'b0);
    end
    run_op(8'd7, 8'd200, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
